// File: rtl/fetch_pkg.sv
// Shared types and default constants for the RV32I instruction fetch stage.
// The optional FETCH_STATS_EN build adds fetch/kill counters in fetch_stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
// PC fields are left untouched by flush and bubble since ValidD=0 marks them as don't-care.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_stall,
  input  logic            i_load,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus4,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_valid
);

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_stall) begin
      r_valid <= r_valid;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end else begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns PCF, keeps one imem request in flight, parks a response while decode stalls.
// Define FETCH_STATS_EN to add the FetchCount/KillCount outputs.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemRvalid,
  input  logic [31:0]     ImemRdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     FetchCount,
  output logic [31:0]     KillCount
`endif
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_hold_pc;
  logic [31:0]     r_hold_instr;
  logic            r_hold_valid;

  logic [XLEN-1:0] w_pcf_plus4;
  logic            w_accept;
  logic            w_load;
  logic            w_drop;
  logic [31:0]     w_load_instr;
  logic [XLEN-1:0] w_load_pc;

  assign w_pcf_plus4 = r_pcf + XLEN'(4);
  assign w_accept    = ImemRvalid && !PCSrcE && !StallD;

  // Request must be combinational so an accepted response can reissue in the same cycle.
  always_comb begin
    ImemReq      = 1'b0;
    ImemAddr     = r_pcf;
    w_load       = 1'b0;
    w_drop       = 1'b0;
    w_load_instr = ImemRdata;
    w_load_pc    = r_pcf;
    case (r_state)
      IDLE: ImemReq = !StallF && !PCSrcE;
      WAIT: begin
        if (ImemRvalid && PCSrcE) begin
          w_drop = 1'b1;
        end else if (w_accept) begin
          w_load   = 1'b1;
          ImemReq  = !StallF;
          ImemAddr = w_pcf_plus4;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          w_drop = 1'b1;
        end else if (r_hold_valid && !StallD) begin
          w_load       = 1'b1;
          w_load_instr = r_hold_instr;
          w_load_pc    = r_hold_pc;
        end
      end
      KILL: w_drop = ImemRvalid;
      default: ;
    endcase
    if (reset) ImemReq = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pcf        <= RESET_PC;
      r_hold_pc    <= '0;
      r_hold_instr <= NOP_INSTR;
      r_hold_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (PCSrcE)       r_pcf   <= PCTargetE;
          else if (!StallF) r_state <= WAIT;
        end
        WAIT: begin
          if (w_drop) begin
            r_pcf   <= PCTargetE;
            r_state <= IDLE;
          end else if (ImemRvalid && StallD) begin
            r_hold_instr <= ImemRdata;
            r_hold_pc    <= r_pcf;
            r_hold_valid <= 1'b1;
            r_state      <= HOLD;
          end else if (w_accept) begin
            r_pcf   <= w_pcf_plus4;
            r_state <= StallF ? IDLE : WAIT;
          end else if (PCSrcE) begin
            r_pcf   <= PCTargetE;
            r_state <= KILL;
          end
        end
        HOLD: begin
          if (w_drop) begin
            r_hold_valid <= 1'b0;
            r_pcf        <= PCTargetE;
            r_state      <= IDLE;
          end else if (w_load) begin
            r_hold_valid <= 1'b0;
            r_pcf        <= w_pcf_plus4;
            r_state      <= IDLE;
          end
        end
        KILL: begin
          if (PCSrcE) r_pcf   <= PCTargetE;
          if (w_drop) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (reset),
    .i_flush    (FlushD),
    .i_stall    (StallD),
    .i_load     (w_load),
    .i_instr    (w_load_instr),
    .i_pc       (w_load_pc),
    .i_pc_plus4 (w_load_pc + XLEN'(4)),
    .o_instr    (InstrD),
    .o_pc       (PCD),
    .o_pc_plus4 (PCPlus4D),
    .o_valid    (ValidD)
  );

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_kill_count;

  // A load that coincides with FlushD never lands in IF/ID, so it is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count <= '0;
      r_kill_count  <= '0;
    end else begin
      if (w_load && !FlushD) r_fetch_count <= r_fetch_count + 32'd1;
      if (w_drop)            r_kill_count  <= r_kill_count + 32'd1;
    end
  end

  assign FetchCount = r_fetch_count;
  assign KillCount  = r_kill_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a variable-latency in-order imem model.
// Each task drives one scenario cycle by cycle and checks outputs at the falling edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemRvalid;
  logic [31:0] ImemRdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
`ifdef FETCH_STATS_EN
  logic [31:0] FetchCount;
  logic [31:0] KillCount;
`endif

  int errors = 0;
  int checks = 0;

  int          mem_lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemRvalid (ImemRvalid),
    .ImemRdata  (ImemRdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
`ifdef FETCH_STATS_EN
    ,
    .FetchCount (FetchCount),
    .KillCount  (KillCount)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0010_0093;
    return {12'hABC, a[19:0]};
  endfunction

  // Imem model: request seen in a cycle is answered mem_lat cycles later.
  initial begin : mem_model
    ImemRvalid = 1'b0;
    ImemRdata  = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_pend && mem_cnt <= 1) begin
        ImemRvalid = 1'b1;
        ImemRdata  = mem_word(mem_addr);
        mem_pend   = 1'b0;
      end else begin
        ImemRvalid = 1'b0;
        ImemRdata  = 32'hDEAD_BEEF;
        if (mem_pend) mem_cnt = mem_cnt - 1;
      end
      @(negedge clk);
      if (ImemReq && !reset) begin
        mem_pend = 1'b1;
        mem_cnt  = mem_lat;
        mem_addr = ImemAddr;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCTargetE = 32'h0; mem_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ImemReq, ValidD, InstrD, PCD, PCPlus4D} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_values: got req=%b v=%b instr=%h pcd=%h pc4=%h, want 0 0 %h 0 0",
               ImemReq, ValidD, InstrD, PCD, PCPlus4D, NOP);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if ({ImemReq, ImemAddr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL reset_first_req: got req=%b addr=%h, want 1 00000000", ImemReq, ImemAddr);
    end
    $display("[reset] req=%b addr=%h validd=%b", ImemReq, ImemAddr, ValidD);
  endtask

  task automatic test_back_to_back();
    mem_lat = 1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      checks++;
      if ({ImemReq, ImemAddr} !== {1'b1, 32'(4 * i)}) begin
        errors++;
        $display("FAIL b2b_req[%0d]: got req=%b addr=%h, want 1 %h", i, ImemReq, ImemAddr, 32'(4 * i));
      end
      if (i == 1) begin
        checks++;
        if (ValidD !== 1'b0) begin
          errors++;
          $display("FAIL b2b_first_bubble: got validd=%b, want 0", ValidD);
        end
      end
      if (i >= 2) begin
        checks++;
        if ({ValidD, InstrD, PCD, PCPlus4D} !== {1'b1, mem_word(32'(4 * (i - 2))), 32'(4 * (i - 2)), 32'(4 * (i - 1))}) begin
          errors++;
          $display("FAIL b2b_ifid[%0d]: got v=%b instr=%h pcd=%h pc4=%h, want 1 %h %h %h", i,
                   ValidD, InstrD, PCD, PCPlus4D, mem_word(32'(4 * (i - 2))), 32'(4 * (i - 2)), 32'(4 * (i - 1)));
        end
      end
      $display("[b2b] cyc=%0d req=%b addr=%h v=%b pcd=%h instr=%h", i, ImemReq, ImemAddr, ValidD, PCD, InstrD);
    end
  endtask

  task automatic test_stall_hold();
    mem_lat = 1;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      StallD = (c >= 3 && c <= 5);
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        checks++;
        if ({ImemReq, ValidD, PCD, InstrD} !== {1'b0, 1'b1, 32'h4, mem_word(32'h4)}) begin
          errors++;
          $display("FAIL hold_cyc%0d: got req=%b v=%b pcd=%h instr=%h, want 0 1 00000004 %h",
                   c, ImemReq, ValidD, PCD, InstrD, mem_word(32'h4));
        end
      end
      if (c == 7) begin
        checks++;
        if ({ImemReq, ImemAddr, ValidD, PCD, PCPlus4D, InstrD} !== {1'b1, 32'hC, 1'b1, 32'h8, 32'hC, mem_word(32'h8)}) begin
          errors++;
          $display("FAIL hold_release: got req=%b addr=%h v=%b pcd=%h pc4=%h instr=%h, want 1 0000000c 1 00000008 0000000c %h",
                   ImemReq, ImemAddr, ValidD, PCD, PCPlus4D, InstrD, mem_word(32'h8));
        end
      end
      if (c == 8) begin
        checks++;
        if ({ImemReq, ImemAddr, ValidD} !== {1'b1, 32'h10, 1'b0}) begin
          errors++;
          $display("FAIL hold_resume: got req=%b addr=%h v=%b, want 1 00000010 0", ImemReq, ImemAddr, ValidD);
        end
      end
      if (c == 9) begin
        checks++;
        if ({ValidD, PCD} !== {1'b1, 32'hC}) begin
          errors++;
          $display("FAIL hold_next_instr: got v=%b pcd=%h, want 1 0000000c", ValidD, PCD);
        end
      end
      $display("[stall] cyc=%0d stalld=%b req=%b addr=%h v=%b pcd=%h", c, StallD, ImemReq, ImemAddr, ValidD, PCD);
    end
  endtask

  task automatic test_kill();
    mem_lat = 3;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      PCSrcE    = (c == 1);
      PCTargetE = 32'h100;
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        checks++;
        if (ImemReq !== 1'b0) begin
          errors++;
          $display("FAIL kill_noreq_cyc%0d: got req=%b, want 0", c, ImemReq);
        end
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (ValidD !== 1'b0) begin
          errors++;
          $display("FAIL kill_stale_cyc%0d: got validd=%b, want 0", c, ValidD);
        end
      end
      if (c == 4) begin
        checks++;
        if ({ImemReq, ImemAddr} !== {1'b1, 32'h100}) begin
          errors++;
          $display("FAIL kill_target_req: got req=%b addr=%h, want 1 00000100", ImemReq, ImemAddr);
        end
      end
      if (c == 8) begin
        checks++;
        if ({ValidD, PCD, InstrD} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
          errors++;
          $display("FAIL kill_target_instr: got v=%b pcd=%h instr=%h, want 1 00000100 %h",
                   ValidD, PCD, InstrD, mem_word(32'h100));
        end
      end
      $display("[kill] cyc=%0d pcsrc=%b rvalid=%b req=%b addr=%h v=%b", c, PCSrcE, ImemRvalid, ImemReq, ImemAddr, ValidD);
    end
  endtask

  task automatic test_redirect_flush();
    mem_lat = 1;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      PCSrcE    = (c == 1);
      FlushD    = (c == 1);
      PCTargetE = 32'h200;
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({ImemRvalid, ImemReq} !== {1'b1, 1'b0}) begin
          errors++;
          $display("FAIL redir_same_cycle: got rvalid=%b req=%b, want 1 0", ImemRvalid, ImemReq);
        end
      end
      if (c == 2) begin
        checks++;
        if ({InstrD, ValidD, ImemReq, ImemAddr} !== {NOP, 1'b0, 1'b1, 32'h200}) begin
          errors++;
          $display("FAIL redir_flush: got instr=%h v=%b req=%b addr=%h, want %h 0 1 00000200",
                   InstrD, ValidD, ImemReq, ImemAddr, NOP);
        end
      end
      if (c == 4) begin
        checks++;
        if ({ValidD, PCD, InstrD} !== {1'b1, 32'h200, mem_word(32'h200)}) begin
          errors++;
          $display("FAIL redir_target_instr: got v=%b pcd=%h instr=%h, want 1 00000200 %h",
                   ValidD, PCD, InstrD, mem_word(32'h200));
        end
      end
      $display("[redir] cyc=%0d req=%b addr=%h v=%b pcd=%h instr=%h", c, ImemReq, ImemAddr, ValidD, PCD, InstrD);
    end
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    do_reset();
    PCSrcE    = 1'b1;
    PCTargetE = 32'hFFFF_FFFC;
    @(negedge clk);
    checks++;
    if (ImemReq !== 1'b0) begin
      errors++;
      $display("FAIL wrap_redirect_idle: got req=%b, want 0", ImemReq);
    end
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      PCSrcE = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({ImemReq, ImemAddr} !== {1'b1, 32'hFFFF_FFFC}) begin
          errors++;
          $display("FAIL wrap_req_top: got req=%b addr=%h, want 1 fffffffc", ImemReq, ImemAddr);
        end
      end
      if (c == 2) begin
        checks++;
        if ({ImemReq, ImemAddr} !== {1'b1, 32'h0}) begin
          errors++;
          $display("FAIL wrap_req_zero: got req=%b addr=%h, want 1 00000000", ImemReq, ImemAddr);
        end
      end
      if (c == 3) begin
        checks++;
        if ({ValidD, PCD, PCPlus4D, InstrD} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'hABCF_FFFC}) begin
          errors++;
          $display("FAIL wrap_ifid: got v=%b pcd=%h pc4=%h instr=%h, want 1 fffffffc 00000000 abcffffc",
                   ValidD, PCD, PCPlus4D, InstrD);
        end
      end
      $display("[wrap] cyc=%0d req=%b addr=%h v=%b pcd=%h pc4=%h", c, ImemReq, ImemAddr, ValidD, PCD, PCPlus4D);
    end
  endtask

  task automatic test_reset_during_wait();
    mem_lat = 1;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) mem_lat = 3;
      if (c == 3) reset = 1'b1;
      if (c == 4) reset = 1'b0;
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if ({ValidD, PCD} !== {1'b1, 32'h0}) begin
          errors++;
          $display("FAIL rstw_before: got v=%b pcd=%h, want 1 00000000", ValidD, PCD);
        end
      end
      if (c == 3) begin
        checks++;
        if ({ImemReq, ValidD, InstrD, PCD, PCPlus4D} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
          errors++;
          $display("FAIL rstw_async: got req=%b v=%b instr=%h pcd=%h pc4=%h, want 0 0 %h 0 0",
                   ImemReq, ValidD, InstrD, PCD, PCPlus4D, NOP);
        end
      end
      if (c == 4) begin
        checks++;
        if ({ImemReq, ImemAddr} !== {1'b1, 32'h0}) begin
          errors++;
          $display("FAIL rstw_first_req: got req=%b addr=%h, want 1 00000000", ImemReq, ImemAddr);
        end
      end
      if (c == 5) begin
        checks++;
        if (ValidD !== 1'b0) begin
          errors++;
          $display("FAIL rstw_late_rvalid: got validd=%b, want 0", ValidD);
        end
      end
      if (c == 8) begin
        checks++;
        if ({ValidD, PCD, PCPlus4D, InstrD} !== {1'b1, 32'h0, 32'h4, 32'h0000_0013}) begin
          errors++;
          $display("FAIL rstw_refetch: got v=%b pcd=%h pc4=%h instr=%h, want 1 00000000 00000004 00000013",
                   ValidD, PCD, PCPlus4D, InstrD);
        end
      end
      $display("[rstwait] cyc=%0d rst=%b rvalid=%b req=%b addr=%h v=%b pcd=%h", c, reset, ImemRvalid, ImemReq, ImemAddr, ValidD, PCD);
    end
  endtask

  initial begin : main
    test_reset();
    test_back_to_back();
    test_stall_hold();
    test_kill();
    test_redirect_flush();
    test_wrap();
    test_reset_during_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch front end of the 5-stage RV32I pipeline. It owns PCF, issues requests to a variable-latency instruction memory, and holds responses while decode is stalled. It also drives the IF/ID pipeline register whose InstrD[6:0] feeds the decode-stage main decoder. It honours StallF/StallD/FlushD from the hazard unit and PCSrcE/PCTargetE redirects from execute.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PCF value after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
StallF  in  1  hazard unit: suppress new request / hold PCF
StallD  in  1  hazard unit: hold IF/ID contents
FlushD  in  1  hazard unit: bubble IF/ID (priority over StallD)
PCSrcE  in  1  execute redirect strobe
PCTargetE  in  XLEN  redirect target
ImemReq  out  1  request strobe, accepted in the cycle asserted
ImemAddr  out  XLEN  request address
ImemRvalid  in  1  response valid (arrives ≥1 cycle after request, in order)
ImemRdata  in  32  response instruction
InstrD  out  32  IF/ID instruction
PCD  out  XLEN  IF/ID PC
PCPlus4D  out  XLEN  IF/ID PC+4
ValidD  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, active-high): PCF=RESET_PC; state=IDLE; HoldValid=0; InstrD=NOP_INSTR; PCD=0; PCPlus4D=0; ValidD=0. ImemReq=0 while reset is asserted.
- At most one request outstanding. Responses are in order. All PC arithmetic is modulo 2^XLEN; PCF+4 wraps at 32'hFFFF_FFFC -> 0.
- "Accept" means ImemRvalid && !PCSrcE && !StallD.
- IDLE: ImemReq = !StallF && !PCSrcE; ImemAddr=PCF. Issued -> WAIT. PCSrcE -> PCF<=PCTargetE, stay IDLE.
- WAIT, no rvalid: PCSrcE -> PCF<=PCTargetE, go KILL.
- WAIT, rvalid and PCSrcE: drop the response, PCF<=PCTargetE, go IDLE.
- WAIT, rvalid and StallD: capture {ImemRdata, PCF} into the hold buffer, HoldValid=1, go HOLD.
- WAIT, accept: load IF/ID with {ImemRdata, PCF, PCF+4, ValidD=1}; PCF<=PCF+4. If !StallF, issue back-to-back in the same cycle (ImemReq=1, ImemAddr=PCF+4) and stay WAIT; otherwise go IDLE. With 1-cycle memory this gives 1 instruction/cycle.
- HOLD: if !StallD, move the buffer to IF/ID, HoldValid=0, PCF<=PCF+4, go IDLE. PCSrcE -> drop the buffer, PCF<=PCTargetE, go IDLE. PCSrcE has priority.
- KILL: the next rvalid is discarded -> IDLE. Further PCSrcE only updates PCF.
- IF/ID update priority:
  - FlushD: InstrD=NOP_INSTR, ValidD=0.
  - else StallD: hold all fields.
  - else new instruction: load it.
  - else bubble: NOP_INSTR, ValidD=0.
- A flushed or dropped response never reaches ValidD=1.

Optional Feature:
FETCH_STATS_EN. When defined, adds two outputs:
- FetchCount (32): increments on each instruction loaded into IF/ID.
- KillCount (32): increments on each discarded response or dropped hold buffer.
Both reset to 0 and wrap at 2^32. When not defined, neither port nor counter exists.

Decomposition:
Shared package fetch_pkg holds:
- fetch_state_t enum {IDLE, WAIT, HOLD, KILL}
- NOP_INSTR constant
- RESET_PC default

One sub-module: if_id_reg. It is the IF/ID register with flush/stall/load/bubble priority, with async reset.

Test Plan:
- Reset, 1-cycle memory returning 32'h0000_0013, then 32'h0010_0093 -> ImemAddr 0,4,8 on consecutive cycles; PCD=0 then 4; ValidD=1 every cycle after the first response.
- StallD for 3 cycles while the response at PC 8 arrives -> HOLD entered; ImemReq=0; IF/ID unchanged. Release -> InstrD at PCD=8 next cycle, then fetch resumes at 12.
- 3-cycle latency memory, PCSrcE with PCTargetE=32'h100 one cycle after the request -> KILL; the stale response is dropped (ValidD=0). Next ImemAddr=32'h100.
- PCSrcE in the same cycle as rvalid, with FlushD=1 -> response dropped, InstrD=NOP_INSTR, ValidD=0, next request to target.
- PCF=32'hFFFF_FFFC fetch -> PCPlus4D=0, next ImemAddr=0.
- Assert reset during WAIT -> outputs return to reset values immediately. A late rvalid after reset release is ignored, and the first request goes to RESET_PC.
